div_seq: RTL and testbench

Multi-cycle iterative divider for the MIPS datapath. It is the inverse companion to the single-cycle multiplier: it accepts a DIV/DIVU request through a start/busy/done handshake. It produces quotient (destined for LO) and remainder (destined for HI) after a fixed latency. The controller uses `done` as the write-enable pulse for the HI/LO registers and stalls on `busy`.

---
 rtl/dp_pkg.sv | 16 +
 rtl/div_step.sv | 33 +++
 rtl/div_seq.sv | 166 ++++++++++++++++
 tb/tb_div_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared datapath definitions for the iterative divider: FSM encoding and
// the sizing rule for the iteration counter.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence one extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor when it fits, and shift
// the resulting quotient bit into the quotient register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic [WIDTH-1:0] qreg_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] prem_o,
  output logic [WIDTH-1:0] qreg_o
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Trial subtraction; the low-WIDTH difference is exact whenever it fits,
  // because the partial remainder is always below the divisor.
  always_comb begin
    shifted_s = {prem_i, qreg_i[WIDTH-1]};
    fits_s    = (shifted_s >= {1'b0, divisor_i});
    diff_s    = shifted_s[WIDTH-1:0] - divisor_i;
    if (fits_s) begin
      prem_o = diff_s;
      qreg_o = {qreg_i[WIDTH-2:0], 1'b1};
    end else begin
      prem_o = shifted_s[WIDTH-1:0];
      qreg_o = {qreg_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU. Works on magnitudes with
// one restoring step per cycle, then sign-corrects in a final cycle and
// pulses done_o as the HI/LO write enable.
module div_seq
  import dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dbz_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] step_prem_s;
  logic [WIDTH-1:0] step_qreg_s;

  // Two's-complement negate when n is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    if (n) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .qreg_i    (qreg_q),
    .divisor_i (bmag_q),
    .prem_o    (step_prem_s),
    .qreg_o    (step_qreg_s)
  );

  // Next-state and datapath control; results only change in FIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bmag_d  = bmag_q;
    prem_d  = prem_q;
    qreg_d  = qreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sgn_d  = sgn_i;
          sa_d   = a_i[WIDTH-1];
          sb_d   = b_i[WIDTH-1];
          bmag_d = neg_if(b_i, sgn_i & b_i[WIDTH-1]);
          qreg_d = neg_if(a_i, sgn_i & a_i[WIDTH-1]);
          prem_d = {WIDTH{1'b0}};
          cnt_d  = CW'(WIDTH);
          busy_d = 1'b1;
          if (b_i == {WIDTH{1'b0}}) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        prem_d = step_prem_s;
        qreg_d = step_qreg_s;
        cnt_d  = cnt_q - CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bmag_q == {WIDTH{1'b0}}) begin
          // No steps ran, so qreg still holds |a|; undoing the dividend
          // sign recovers the original operand for HI.
          quo_d = {WIDTH{1'b1}};
          rem_d = neg_if(qreg_q, sgn_q & sa_q);
          dbz_d = 1'b1;
        end else begin
          quo_d = neg_if(qreg_q, sgn_q & (sa_q ^ sb_q));
          rem_d = neg_if(prem_q, sgn_q & sa_q);
          dbz_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, working and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bmag_q  <= {WIDTH{1'b0}};
      prem_q  <= {WIDTH{1'b0}};
      qreg_q  <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bmag_q  <= bmag_d;
      prem_q  <= prem_d;
      qreg_q  <= qreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dbz_o  = dbz_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .sgn_i   (sgn),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .quo_o   (quo),
    .rem_o   (rem),
    .dbz_o   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero.
  function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sx;
    longint sy;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
      z = 1'b1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
      z  = 1'b0;
    end else begin
      q = x / y;
      r = x % y;
      z = 1'b0;
    end
  endfunction

  // Launch one operation and check latency, hold behaviour and results.
  task automatic run_op(input string name, input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eq, er, oq, orr;
    logic ez, held;
    int n;
    model(s, x, y, eq, er, ez);
    oq = quo; orr = rem; held = 1'b1;
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sgn = ~s;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
    while (done !== 1'b1 && n < 100) begin
      if (quo !== oq || rem !== orr) held = 1'b0;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== ((y == 32'd0) ? 2 : 34)) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, n, (y == 32'd0) ? 2 : 34);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL %s hold: results changed before done", name); end
    checks++;
    if (quo !== eq || rem !== er || dbz !== ez) begin
      errors++;
      $display("FAIL %s result: got q=%h r=%h z=%b want q=%h r=%h z=%b", name, quo, rem, dbz, eq, er, ez);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: done high two cycles", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    checks++;
    if ({busy, done, dbz} !== 3'b000 || quo !== 32'd0 || rem !== 32'd0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b dbz=%b q=%h r=%h want zeros", busy, done, dbz, quo, rem);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op("u100_7", 1'b0, 32'd100, 32'd7);
  endtask

  task automatic test_signed();
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_dbz();
    run_op("dbz", 1'b0, 32'h1234, 32'd0);
    run_op("after_dbz", 1'b0, 32'd9, 32'd3);
    run_op("dbz_signed", 1'b1, 32'hFFFF_FF00, 32'd0);
  endtask

  task automatic test_overflow();
    run_op("ovf_s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("ovf_u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5;
    @(posedge clk); #1; start = 1'b0; n = 1;
    while (done !== 1'b1 && n < 100) begin
      if (n == 9) begin start = 1'b1; a = 32'd9; b = 32'd2; end
      else begin start = 1'b0; end
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 34 || quo !== 32'd10 || rem !== 32'd0) begin
      errors++; $display("FAIL ignore_start: got n=%0d q=%0d r=%0d want n=34 q=10 r=0", n, quo, rem);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd9; b = 32'd2;
    @(posedge clk); #1; n = 1;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 34 || quo !== 32'd4 || rem !== 32'd1) begin
      errors++; $display("FAIL b2b_first: got n=%0d q=%0d r=%0d want n=34 q=4 r=1", n, quo, rem);
    end
    @(posedge clk); #1; start = 1'b0; n = 1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
    end
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 34 || quo !== 32'd4 || rem !== 32'd1) begin
      errors++; $display("FAIL b2b_second: got n=%0d q=%0d r=%0d want n=34 q=4 r=1", n, quo, rem);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dbz} !== 3'b000 || quo !== 32'd0 || rem !== 32'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h want zeros", busy, done, quo, rem);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid_quiet: got activity after reset want none"); end
    run_op("after_reset", 1'b0, 32'd1000, 32'd3);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 25; i++) begin
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: y = $urandom;
      endcase
      run_op("random", 1'($urandom_range(0, 1)), x, y);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
